// File: rtl/count_display_mux_pkg.sv
// Shared constants and helpers for the count display path: segment codes,
// conversion FSM states and constant-width helpers.
package count_display_mux_pkg;

    // {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    // Never returns 0 so single-value counters still get a 1-bit register.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/count_display_mux_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, WIDTH shifts,
// then a COMMIT cycle that flags the finished BCD on done.
module bin2bcd_seq
    import count_display_mux_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd
);
    localparam int BW = DIGITS * 4;
    localparam int CW = clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    scratch, adj;
    logic [CW-1:0]    bitcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (bitcnt == CW'(1)) state_nxt = COMMIT;
            COMMIT: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // add-3 correction applied before each shift
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            scratch <= '0;
            bitcnt  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    shreg   <= bin;
                    scratch <= '0;
                    bitcnt  <= CW'(WIDTH);
                end
                SHIFT: begin
                    {scratch, shreg} <= {adj, shreg} << 1;
                    bitcnt           <= bitcnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bcd = scratch;

endmodule

// File: rtl/count_display_mux.sv
// Captures the counter value, converts it to BCD and scans the digits onto a
// common-anode 7-segment display with optional leading-zero blanking.
module count_display_mux
    import count_display_mux_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 16,
    parameter int BLANK_LZ    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  value,
    input  logic              load,
    output logic              busy,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              dp
);
    localparam int RW = clog2(REFRESH_DIV);
    localparam int IW = clog2(DIGITS);

    if ((longint'(1) << WIDTH) > pow10(DIGITS)) begin : g_width_chk
        $error("WIDTH too large for DIGITS");
    end
    if (REFRESH_DIV < 2) begin : g_div_chk
        $error("REFRESH_DIV must be >= 2");
    end

    logic [DIGITS*4-1:0] conv_bcd, disp;
    logic                conv_done;
    logic [RW-1:0]       ref_cnt;
    logic [IW-1:0]       dig_idx;
    logic [DIGITS:0]     zero_from;
    logic [3:0]          nib;
    logic                blank_cur;
    logic [6:0]          seg_nxt;
    logic [DIGITS-1:0]   an_nxt;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (load),
        .bin   (value),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            disp <= '0;
        else if (conv_done) disp <= conv_bcd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
            dig_idx <= '0;
        end else if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            dig_idx <= (dig_idx == IW'(DIGITS - 1)) ? '0 : dig_idx + IW'(1);
        end else begin
            ref_cnt <= ref_cnt + RW'(1);
        end
    end

    // zero_from[k]: digit k and every digit above it are zero
    always_comb begin
        zero_from         = '0;
        zero_from[DIGITS] = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--)
            zero_from[k] = zero_from[k+1] && (disp[4*k +: 4] == 4'd0);
    end

    always_comb begin
        nib       = '0;
        blank_cur = 1'b0;
        an_nxt    = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_idx == IW'(k)) begin
                nib       = disp[4*k +: 4];
                blank_cur = (BLANK_LZ != 0) && (k != 0) && zero_from[k];
                an_nxt[k] = 1'b0;
            end
        end
        seg_nxt = blank_cur ? SEG_BLANK : seg_decode(nib);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_count_display_mux.sv
// Scoreboard bench: stimulus queues the expected display per conversion or
// reset release; per-DUT monitors scan one full refresh frame and compare.
module tb_count_display_mux;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SB = 7'b1111111;

    typedef struct {
        logic [3:0][6:0] seg;   // index = digit
        int              blen;  // -1: reset-release entry
    } exp_t;

    logic       clk = 0;
    logic       rst = 1;
    logic [7:0] value = '0;
    logic       load = 0, load1 = 0;
    logic       busy0, busy1, dp0, dp1;
    logic [6:0] seg0, seg1;
    logic [3:0] an0, an1;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    count_display_mux #(.WIDTH(8), .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy0), .seg(seg0), .an(an0), .dp(dp0)
    );

    count_display_mux #(.WIDTH(8), .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .value(value), .load(load1),
        .busy(busy1), .seg(seg1), .an(an1), .dp(dp1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit which, input logic [6:0] d3, input logic [6:0] d2,
                        input logic [6:0] d1, input logic [6:0] d0, input int bl);
        exp_t e;
        e.seg  = {d3, d2, d1, d0};
        e.blen = bl;
        if (which) q1.push_back(e);
        else       q0.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic monitor(input bit which);
        exp_t            e;
        logic            pr, pb, b, trig, chk_b, have, bad_an, bad_dp;
        int              blen, idx;
        int              cnt[4];
        logic [3:0]      a;
        logic [6:0]      s;
        logic [3:0][6:0] segs;
        pr = 1; pb = 0; blen = 0;
        forever begin
            @(negedge clk);
            b     = which ? busy1 : busy0;
            trig  = 0;
            chk_b = 0;
            if (pr && !rst) trig = 1;
            else if (!rst && pb && !b) begin trig = 1; chk_b = 1; end
            if (rst)    blen = 0;
            else if (b) blen++;
            pr = rst;
            pb = b;
            if (trig) begin
                have = 0;
                if (which ? (q1.size() == 0) : (q0.size() == 0)) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_event dut%0d: no expected entry queued", which);
                end else begin
                    e    = which ? q1.pop_front() : q0.pop_front();
                    have = 1;
                    check($sformatf("busy_len dut%0d", which), chk_b ? blen : -1, e.blen);
                end
                blen = 0;
                repeat (2) @(negedge clk);
                segs   = {4{SB}};
                bad_an = 0;
                bad_dp = 0;
                for (int k = 0; k < 4; k++) cnt[k] = 0;
                for (int i = 0; i < 16; i++) begin
                    @(negedge clk);
                    a = which ? an1 : an0;
                    s = which ? seg1 : seg0;
                    if ((which ? dp1 : dp0) !== 1'b1) bad_dp = 1;
                    case (a)
                        4'b1110: idx = 0;
                        4'b1101: idx = 1;
                        4'b1011: idx = 2;
                        4'b0111: idx = 3;
                        default: idx = -1;
                    endcase
                    if (idx < 0) bad_an = 1;
                    else begin
                        segs[idx] = s;
                        cnt[idx]++;
                    end
                end
                check($sformatf("an_onehot dut%0d", which), {31'd0, bad_an}, 0);
                check($sformatf("dp_off dut%0d", which), {31'd0, bad_dp}, 0);
                for (int k = 0; k < 4; k++)
                    check($sformatf("slot_len dut%0d d%0d", which, k), cnt[k], 4);
                if (have)
                    for (int k = 0; k < 4; k++)
                        check($sformatf("seg dut%0d d%0d", which, k), {25'd0, segs[k]}, {25'd0, e.seg[k]});
                pr = rst;
                pb = which ? busy1 : busy0;
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("reset busy", {31'd0, busy0}, 0);
        check("reset an", {28'd0, an0}, 32'hF);
        check("reset seg", {25'd0, seg0}, {25'd0, SB});
        check("reset dp", {31'd0, dp0}, 1);

        // 1: idle after reset shows a single "0"
        push(0, SB, SB, SB, S0, -1);
        push(1, S0, S0, S0, S0, -1);
        rst = 0;
        tick(25);

        // 2: 255
        push(0, SB, S2, S5, S5, 9);
        load = 1; value = 8'd255;
        tick(1); load = 0;
        tick(35);

        // 3: 0 after 255
        push(0, SB, SB, SB, S0, 9);
        load = 1; value = 8'd0;
        tick(1); load = 0;
        tick(35);

        // 4: 100 with a load of 7 while busy (ignored)
        push(0, SB, S1, S0, S0, 9);
        load = 1; value = 8'd100;
        tick(1); load = 0;
        tick(2); load = 1; value = 8'd7;
        tick(1); load = 0;
        tick(35);

        // 5: reset four cycles into a conversion of 200
        load = 1; value = 8'd200;
        tick(1); load = 0;
        tick(3);
        rst = 1;
        #1;
        check("abort busy", {31'd0, busy0}, 0);
        check("abort an", {28'd0, an0}, 32'hF);
        check("abort seg", {25'd0, seg0}, {25'd0, SB});
        tick(2);
        push(0, SB, SB, SB, S0, -1);
        push(1, S0, S0, S0, S0, -1);
        rst = 0;
        tick(25);
        push(0, SB, SB, S4, S2, 9);
        load = 1; value = 8'd42;
        tick(1); load = 0;
        tick(35);

        // 6: no blanking instance, value 5
        push(1, S0, S0, S0, S5, 9);
        load1 = 1; value = 8'd5;
        tick(1); load1 = 0;
        tick(35);

        check("q0 drained", q0.size(), 0);
        check("q1 drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
